// File: rtl/dff_sync_pkg.sv
// Shared constants and helpers for the per-channel synchroniser/filter.
`timescale 1ns/1ps

package dff_sync_pkg;

    // A chain shorter than this gives no useful MTBF margin.
    localparam int DFF_SYNC_MIN_DEPTH  = 2;

    // The filter needs at least one edge to adopt a new level.
    localparam int DFF_FILT_MIN_CYCLES = 1;

    // Width of the stability counter: enough to hold FILT_CYCLES-1, but never zero bits.
    function automatic int cnt_width(input int filt_cycles);
        int w;
        w = $clog2(filt_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_filter_bit.sv
// One channel's debounce filter: stability counter, filtered level, edge pulses, busy flag.
`timescale 1ns/1ps

module dff_filter_bit
    import dff_sync_pkg::*;
#(
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic filt_en,
    input  logic sync_in,
    output logic data,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          data_next;

    // Decide the next filtered level and counter; bypass follows the synced level directly.
    always_comb begin
        cnt_next  = '0;
        data_next = data;
        if (!filt_en) begin
            data_next = sync_in;
        end else if (sync_in != data) begin
            if (cnt == CNT_LAST) begin
                data_next = sync_in;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Register level, counter and the flags derived from the next state so they align with data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            data <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
            busy <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            data <= data_next;
            rise <= data_next & ~data;
            fall <= ~data_next & data;
            busy <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/dff_sync.sv
// Single-bit multi-flop synchroniser; the last stage is the only safe output.
`timescale 1ns/1ps

module dff_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    // Shift the raw level through DEPTH flops, stage 0 being the metastable one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/dff_sync_filter.sv
// Per-channel async-level synchroniser with debounce filter and registered edge detection.
`timescale 1ns/1ps

module dff_sync_filter
    import dff_sync_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
    parameter int               FILT_CYCLES = 4
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             dst_filt_en,
    input  logic [WIDTH-1:0] src_data,
    output logic [WIDTH-1:0] dst_data,
    output logic [WIDTH-1:0] dst_rise,
    output logic [WIDTH-1:0] dst_fall,
    output logic [WIDTH-1:0] dst_busy
);

    if (DEPTH < DFF_SYNC_MIN_DEPTH) begin : g_bad_depth
        $error("dff_sync_filter: DEPTH must be >= %0d", DFF_SYNC_MIN_DEPTH);
    end

    if (FILT_CYCLES < DFF_FILT_MIN_CYCLES) begin : g_bad_filt
        $error("dff_sync_filter: FILT_CYCLES must be >= %0d", DFF_FILT_MIN_CYCLES);
    end

    logic [WIDTH-1:0] sync_data;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        dff_sync #(
            .DEPTH   (DEPTH),
            .RST_VAL (RST_VAL[i])
        ) u_sync (
            .clk   (dst_clk),
            .rst_n (dst_rst_n),
            .d     (src_data[i]),
            .q     (sync_data[i])
        );

        dff_filter_bit #(
            .FILT_CYCLES (FILT_CYCLES),
            .RST_VAL     (RST_VAL[i])
        ) u_filter (
            .clk     (dst_clk),
            .rst_n   (dst_rst_n),
            .filt_en (dst_filt_en),
            .sync_in (sync_data[i]),
            .data    (dst_data[i]),
            .rise    (dst_rise[i]),
            .fall    (dst_fall[i]),
            .busy    (dst_busy[i])
        );
    end

endmodule

// File: tb/tb_dff_sync_filter.sv
// Bench for dff_sync_filter: window-based reference model plus directed scenarios.
`timescale 1ns/1ps

module tb_dff_sync_filter;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 2;
    localparam int         FC    = 4;
    localparam logic [7:0] RSTV  = 8'hA5;

    logic             dst_clk;
    logic             dst_rst_n;
    logic             dst_filt_en;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] dst_data;
    logic [WIDTH-1:0] dst_rise;
    logic [WIDTH-1:0] dst_fall;
    logic [WIDTH-1:0] dst_busy;

    int   n_checks;
    int   n_errors;
    logic chk_en;

    dff_sync_filter #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RST_VAL     (RSTV),
        .FILT_CYCLES (FC)
    ) dut (
        .dst_clk     (dst_clk),
        .dst_rst_n   (dst_rst_n),
        .dst_filt_en (dst_filt_en),
        .src_data    (src_data),
        .dst_data    (dst_data),
        .dst_rise    (dst_rise),
        .dst_fall    (dst_fall),
        .dst_busy    (dst_busy)
    );

    initial begin
        dst_clk = 1'b0;
        forever #5 dst_clk = ~dst_clk;
    end

    // Reference model: src sampled each edge reaches the filter DEPTH edges later; a channel
    // adopts the synced level when the last FC synced samples, all taken with the filter
    // enabled, disagree with the current output. Busy means synced level and output differ.
    logic [7:0] src_hist [DEPTH];
    logic [7:0] s_hist   [FC-1];
    logic       en_hist  [FC-1];
    logic [7:0] m_data, m_rise, m_fall, m_busy;
    logic [7:0] cur_s, nd, nbusy;

    always_comb begin
        cur_s = src_hist[0];
        nd    = m_data;
        nbusy = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic agree;
            agree = 1'b1;
            if (!dst_filt_en) begin
                nd[i] = cur_s[i];
            end else begin
                for (int j = 0; j < FC-1; j++) begin
                    if (!en_hist[j] || s_hist[j][i] == m_data[i]) agree = 1'b0;
                end
                if (cur_s[i] == m_data[i]) agree = 1'b0;
                nd[i] = agree ? cur_s[i] : m_data[i];
            end
        end
        if (dst_filt_en) nbusy = cur_s ^ nd;
    end

    always @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            for (int d = 0; d < DEPTH; d++) src_hist[d] <= RSTV;
            for (int j = 0; j < FC-1; j++) begin
                s_hist[j]  <= RSTV;
                en_hist[j] <= 1'b0;
            end
            m_data <= RSTV;
            m_rise <= '0;
            m_fall <= '0;
            m_busy <= '0;
        end else begin
            for (int d = 0; d < DEPTH-1; d++) src_hist[d] <= src_hist[d+1];
            src_hist[DEPTH-1] <= src_data;
            for (int j = 0; j < FC-2; j++) begin
                s_hist[j]  <= s_hist[j+1];
                en_hist[j] <= en_hist[j+1];
            end
            s_hist[FC-2]  <= cur_s;
            en_hist[FC-2] <= dst_filt_en;
            m_data <= nd;
            m_rise <= nd & ~m_data;
            m_fall <= ~nd & m_data;
            m_busy <= nbusy;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] src, input logic en);
        src_data    = src;
        dst_filt_en = en;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge dst_clk);
            if (chk_en) begin
                checkOutput("model_data", dst_data, m_data);
                checkOutput("model_rise", dst_rise, m_rise);
                checkOutput("model_fall", dst_fall, m_fall);
                checkOutput("model_busy", dst_busy, m_busy);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        chk_en    = 1'b0;
        dst_rst_n = 1'b0;
        applyStimulus(RSTV, 1'b1);
        repeat (3) @(negedge dst_clk);
        dst_rst_n = 1'b1;
        chk_en    = 1'b1;

        // Reset values held with matching src.
        for (int k = 0; k < 20; k++) begin
            @(negedge dst_clk);
            checkOutput("reset_data", dst_data, 8'hA5);
            checkOutput("reset_flags", {dst_rise, dst_fall, dst_busy}, 24'h0);
        end

        applyStimulus(8'h00, 1'b1);
        repeat (8) @(negedge dst_clk);

        // Latency on channel 0.
        applyStimulus(8'h01, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge dst_clk);
            checkOutput("lat_data0", dst_data[0], (k >= 6));
            checkOutput("lat_rise0", dst_rise[0], (k == 6));
            checkOutput("lat_busy0", dst_busy[0], (k >= 3 && k <= 5));
        end
        applyStimulus(8'h00, 1'b1);
        repeat (8) @(negedge dst_clk);

        // Three-cycle glitch on channel 3.
        applyStimulus(8'h08, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge dst_clk);
            if (k == 3) applyStimulus(8'h00, 1'b1);
            checkOutput("glitch_data3", dst_data[3], 1'b0);
            checkOutput("glitch_edges3", {dst_rise[3], dst_fall[3]}, 2'b00);
            checkOutput("glitch_busy3", dst_busy[3], (k >= 3 && k <= 5));
        end
        repeat (2) @(negedge dst_clk);

        // Interrupted qualification on channel 1.
        applyStimulus(8'h02, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge dst_clk);
            if (k == 3) applyStimulus(8'h00, 1'b1);
            if (k == 4) applyStimulus(8'h02, 1'b1);
            checkOutput("intr_data1", dst_data[1], (k >= 10));
            checkOutput("intr_rise1", dst_rise[1], (k == 10));
            checkOutput("intr_busy1", dst_busy[1], ((k >= 3 && k <= 5) || (k >= 7 && k <= 9)));
        end
        applyStimulus(8'h00, 1'b1);
        repeat (8) @(negedge dst_clk);

        // Bypass: one-cycle pulse on channel 2.
        applyStimulus(8'h00, 1'b0);
        repeat (3) @(negedge dst_clk);
        applyStimulus(8'h04, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge dst_clk);
            if (k == 1) applyStimulus(8'h00, 1'b0);
            checkOutput("byp_data2", dst_data[2], (k == 3));
            checkOutput("byp_rise2", dst_rise[2], (k == 3));
            checkOutput("byp_fall2", dst_fall[2], (k == 4));
            checkOutput("byp_busy", dst_busy, 8'h00);
        end
        applyStimulus(8'h00, 1'b1);
        repeat (3) @(negedge dst_clk);

        // Reset while channel 5 is mid-qualification.
        applyStimulus(8'h20, 1'b1);
        repeat (4) @(negedge dst_clk);
        checkOutput("pre_reset_busy5", dst_busy[5], 1'b1);
        #1 dst_rst_n = 1'b0;
        #2;
        checkOutput("mid_reset_data", dst_data, 8'hA5);
        checkOutput("mid_reset_flags", {dst_rise, dst_fall, dst_busy}, 24'h0);
        @(negedge dst_clk);
        dst_rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge dst_clk);
            checkOutput("post_reset_data", dst_data, (k >= 6) ? 8'h20 : 8'hA5);
            checkOutput("post_reset_fall", dst_fall, (k == 6) ? 8'h85 : 8'h00);
            checkOutput("post_reset_rise", dst_rise, 8'h00);
            checkOutput("post_reset_busy", dst_busy, (k >= 3 && k <= 5) ? 8'h85 : 8'h00);
        end

        repeat (3) @(negedge dst_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_sync_filter.md
Name: dff_sync_filter

Overview:
- Multi-bit, per-channel synchroniser for asynchronous level inputs (buttons, straps, status lines) into the dst_clk domain.
- Each channel has a DEPTH-stage flop chain, then a glitch/debounce filter with a stability counter, then registered rise/fall pulse detection.
- Sits at chip/IP boundaries wherever a raw async level must become a clean, debounced, edge-annotated signal.
- Channels are fully independent; this is not a bus synchroniser, and src_data bits carry no coherency guarantee.

Parameters:
- WIDTH, 8: number of independent channels.
- DEPTH, 2: synchroniser flop stages per channel. Must be >= 2; an elaboration error is raised otherwise.
- RST_VAL, {WIDTH{1'b0}}: per-channel reset value of the sync chain and dst_data.
- FILT_CYCLES, 4: consecutive cycles a new synced level must persist before dst_data adopts it. Must be >= 1; an elaboration error is raised otherwise.

Ports:
- dst_clk  input  1  destination clock; the only clock.
- dst_rst_n  input  1  asynchronous, active-low reset, deasserted synchronously to dst_clk by the integrator.
- dst_filt_en  input  1  quasi-static, dst_clk domain. 1 = filter active, 0 = bypass (FILT_CYCLES treated as 1).
- src_data  input  WIDTH  asynchronous raw levels.
- dst_data  output  WIDTH  synchronised, filtered levels (registered).
- dst_rise  output  WIDTH  one-cycle pulse in the first cycle dst_data[i] reads 1 after reading 0 (registered).
- dst_fall  output  WIDTH  one-cycle pulse in the first cycle dst_data[i] reads 0 after reading 1 (registered).
- dst_busy  output  WIDTH  1 while channel i's counter is non-zero, i.e. a candidate change is being qualified (registered).

Behaviour:
- Reset (async assert):
  - sync chains = RST_VAL; dst_data = RST_VAL.
  - counters = 0; dst_rise = dst_fall = dst_busy = 0.
  - No edge pulse is generated by reset assertion or release.
- Sync stage: per channel, DEPTH flops. s[i] = last stage. A src change meeting setup appears on s[i] DEPTH edges later; metastability adds an uncertainty of +1 cycle.
- Filter, per channel, evaluated every edge:
  - s[i] == dst_data[i]: counter <= 0.
  - s[i] != dst_data[i] and counter < FILT_CYCLES-1: counter <= counter+1.
  - s[i] != dst_data[i] and counter == FILT_CYCLES-1: dst_data[i] <= s[i]; counter <= 0.
  - Counter width is clog2(FILT_CYCLES) with a minimum of 1. The counter saturates by construction and never wraps.
- Latency: s[i] change to dst_data[i] change is exactly FILT_CYCLES edges. src to dst_data is DEPTH+FILT_CYCLES edges (+1 for metastability).
- Glitch rejection:
  - A deviation on s[i] lasting fewer than FILT_CYCLES cycles produces no dst_data change.
  - Any single cycle where s[i] equals dst_data[i] restarts qualification from 0.
- Edge pulses:
  - dst_rise[i] <= (next dst_data[i] == 1 && dst_data[i] == 0); dst_fall[i] is the mirror.
  - Both are high in the same cycle the new dst_data value is first visible, for exactly one cycle.
  - Rise and fall are never high together on one channel.
- dst_busy[i] <= (next counter != 0).
- Bypass (dst_filt_en = 0):
  - dst_data[i] <= s[i] every edge; counters are forced to 0; dst_busy = 0.
  - Edge pulses are still generated.
  - Toggling dst_filt_en mid-count clears the counter. No spurious pulse is generated; the next update follows the rules of the new mode.
- Simultaneous events: channels are independent, so any subset may update or pulse in the same cycle.
- Reset mid-qualification: state returns to reset values immediately and the pending change is discarded.

Decomposition:
- Package dff_sync_pkg:
  - constants DFF_SYNC_MIN_DEPTH = 2 and DFF_FILT_MIN_CYCLES = 1;
  - function cnt_width(FILT_CYCLES) returning max(1, clog2(FILT_CYCLES)).
- Sync chain per channel: the existing dff_sync (DEPTH, RST_VAL[i]), instantiated in a generate loop.
- New sub-module dff_filter_bit: one channel's counter, dst_data, rise/fall and busy logic. The top level is generate loops plus parameter checks.

Test Plan:
- Reset values: WIDTH=8, RST_VAL=8'hA5, src_data=8'hA5 held through reset release -> dst_data=8'hA5 and rise/fall/busy=0 for 20 cycles.
- Latency: DEPTH=2, FILT_CYCLES=4, src_data[0] 0->1 just after an edge -> dst_data[0]=1 exactly 6 edges later ±1, with dst_rise[0] high for that one cycle only.
- Glitch rejection: FILT_CYCLES=4, src_data[3] high for 3 cycles, then low -> dst_data[3] stays 0, no pulses, and dst_busy[3] high for 3 cycles.
- Interrupted qualification: src_data[1] high 3 cycles, low 1 cycle, high 4+ cycles -> dst_data[1] rises exactly 4 cycles after s[1] last rises, single dst_rise.
- Bypass: dst_filt_en=0, src_data[2] 1-cycle pulse aligned to the clock -> dst_data[2] shows a 1-cycle pulse DEPTH+1 edges later, with dst_rise then dst_fall on consecutive cycles.
- Reset mid-count: counter at 2 on channel 5, assert dst_rst_n=0 -> outputs go to reset values immediately. After release with src held, qualification restarts from the sync chain output and no pulse appears before DEPTH+FILT_CYCLES edges.
